// File: rtl/rx_read_fifo.sv
// Receive FIFO between the UART receiver and the APB read side; first-word-fall-through, 1-cycle write-to-valid latency.
// Backpressure: ready_in drops while full; characters offered while full are dropped and flagged in sticky overrun_o.
module rx_read_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DATA_WIDTH-1:0]      data_i,
   input  logic                       ferr_i,
   input  logic                       valid_in,
   output logic                       ready_in,
   output logic [DATA_WIDTH-1:0]      data_o,
   output logic                       ferr_o,
   output logic                       valid_out,
   input  logic                       ready_out,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overrun_o,
   input  logic                       clr_ovr
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [DATA_WIDTH:0] mem [DEPTH];
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic                full;
   logic                wr_en;
   logic                rd_en;
   logic                ovr_evt;
   logic [DATA_WIDTH:0] head;

   assign full      = (count == FULL_CNT);
   assign ready_in  = ~full;
   assign valid_out = (count != '0);
   assign wr_en     = valid_in && ready_in;
   assign rd_en     = valid_out && ready_out;
   assign ovr_evt   = valid_in && full;

   // Head is forced to zero when empty so stale storage never leaks out.
   assign head   = mem[rd_ptr];
   assign data_o = valid_out ? head[DATA_WIDTH-1:0] : '0;
   assign ferr_o = valid_out ? head[DATA_WIDTH] : 1'b0;

   always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
         mem[wr_ptr] <= {ferr_i, data_i};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overrun_o <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr_en, rd_en})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         // A new overrun takes priority over a clear in the same cycle.
         if (ovr_evt) begin
            overrun_o <= 1'b1;
         end else if (clr_ovr) begin
            overrun_o <= 1'b0;
         end
      end
   end

endmodule
